process_sequencer: RTL and testbench

Run controller for the matrix-multiplication processor. It debounces the start switch and holds the processor in reset for a fixed window. It then enables execution, waits for `end_process` or a watchdog timeout, and reports a 2-bit status for the LED state controller. It sits in the top level between the board switch and the processor/state-controller pair, replacing ad-hoc start logic.

---
 rtl/proc_pkg.sv | 23 ++
 rtl/switch_debouncer.sv | 31 +++
 rtl/process_sequencer.sv | 99 +++++++++
 tb/tb_process_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared types and defaults for the matrix-processor run controller.
package proc_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_RESET, S_RUN, S_DONE, S_FAULT
  } state_t;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;
  localparam logic [1:0] ST_FAULT = 2'b11;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 10;
  localparam int unsigned DEF_RESET_CYCLES    = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 32'hFFFF;
  localparam int unsigned DEF_CNT_W           = 16;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Counts consecutive high samples of the start switch while armed and flags
// the sample that completes the debounce window.
module switch_debouncer
  import proc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic level,
  output logic stable_high
);

  localparam int unsigned W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0] cnt;

  // Parks at LAST; the FSM leaves ARM on that sample and re-enters via IDLE.
  always_ff @(posedge clock) begin
    if (rst || clear)
      cnt <= '0;
    else if (enable && level && cnt != LAST)
      cnt <= cnt + 1'b1;
  end

  assign stable_high = enable && level && (cnt == LAST);

endmodule

// File: rtl/process_sequencer.sv
// Run controller: debounce start, hold processor in reset, run until
// end_process or watchdog, and report a 2-bit status.
module process_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned RESET_CYCLES    = DEF_RESET_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             start_process,
  input  logic             end_process,
  output logic             proc_rst,
  output logic             proc_run,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] cycle_count,
  output logic             timeout
);

  localparam int unsigned      RW       = cnt_width(RESET_CYCLES);
  localparam logic [RW-1:0]    RST_LAST = RW'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);

  state_t          state, state_nxt;
  logic [RW-1:0]   hold_cnt;
  logic            stable_high;
  logic            timeout_hit;
  logic            run_step;
  logic            reset_entry;

  switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clock       (clock),
    .rst         (rst),
    .clear       (state == S_IDLE),
    .enable      (state == S_ARM),
    .level       (start_process),
    .stable_high (stable_high)
  );

  assign timeout_hit = TO_EN && (cycle_count == TO_LAST);
  // A RUN cycle that neither aborts nor completes advances the counter.
  assign run_step    = (state == S_RUN) && start_process && !end_process;
  assign reset_entry = (state == S_ARM) && (state_nxt == S_RESET);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_process) state_nxt = S_ARM;
      S_ARM:   if (!start_process) state_nxt = S_IDLE;
               else if (stable_high) state_nxt = S_RESET;
      S_RESET: if (!start_process) state_nxt = S_IDLE;
               else if (hold_cnt == RST_LAST) state_nxt = S_RUN;
      S_RUN:   if (!start_process) state_nxt = S_IDLE;
               else if (end_process) state_nxt = S_DONE;
               else if (timeout_hit) state_nxt = S_FAULT;
      S_DONE, S_FAULT: if (!start_process) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    proc_rst = 1'b1;
    proc_run = 1'b0;
    status   = ST_IDLE;
    case (state)
      S_RESET: status = ST_RUN;
      S_RUN:   begin proc_rst = 1'b0; proc_run = 1'b1; status = ST_RUN; end
      S_DONE:  begin proc_rst = 1'b0; status = ST_DONE; end
      S_FAULT: begin proc_rst = 1'b0; status = ST_FAULT; end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state       <= S_IDLE;
      hold_cnt    <= '0;
      cycle_count <= '0;
      timeout     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (reset_entry) begin
        hold_cnt    <= '0;
        cycle_count <= '0;
        timeout     <= 1'b0;
      end else if (state == S_RESET) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      if (run_step) begin
        if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
        if (timeout_hit) timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_process_sequencer.sv
// Directed bench: dut_a uses default parameters, dut_b a 20-cycle watchdog;
// both share the same stimulus.
module tb_process_sequencer;
  import proc_pkg::*;

  logic        clock, rst, start_process, end_process;
  logic        a_proc_rst, a_proc_run, a_timeout;
  logic [1:0]  a_status;
  logic [15:0] a_count;
  logic        b_proc_rst, b_proc_run, b_timeout;
  logic [1:0]  b_status;
  logic [15:0] b_count;

  int n_cmp = 0;
  int n_err = 0;

  process_sequencer dut_a (
    .clock(clock), .rst(rst), .start_process(start_process), .end_process(end_process),
    .proc_rst(a_proc_rst), .proc_run(a_proc_run), .status(a_status),
    .cycle_count(a_count), .timeout(a_timeout)
  );

  process_sequencer #(.TIMEOUT_CYCLES(20)) dut_b (
    .clock(clock), .rst(rst), .start_process(start_process), .end_process(end_process),
    .proc_rst(b_proc_rst), .proc_run(b_proc_run), .status(b_status),
    .cycle_count(b_count), .timeout(b_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_a_proc_rst"}, 32'(a_proc_rst), 1);
    chk({tag, "_a_proc_run"}, 32'(a_proc_run), 0);
    chk({tag, "_a_status"},   32'(a_status),   32'(ST_IDLE));
    chk({tag, "_a_count"},    32'(a_count),    0);
    chk({tag, "_a_timeout"},  32'(a_timeout),  0);
    chk({tag, "_b_proc_rst"}, 32'(b_proc_rst), 1);
    chk({tag, "_b_status"},   32'(b_status),   32'(ST_IDLE));
    chk({tag, "_b_count"},    32'(b_count),    0);
    chk({tag, "_b_timeout"},  32'(b_timeout),  0);
  endtask

  initial begin
    rst = 1'b1; start_process = 1'b0; end_process = 1'b0;
    repeat (2) tick();
    chk_reset_vals("reset");
    rst = 1'b0;

    // Glitch: 5 high samples is short of the 10-sample window.
    start_process = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("glitch_run", 32'(a_proc_run), 0);
      chk("glitch_status", 32'(a_status), 32'(ST_IDLE));
    end
    start_process = 1'b0;
    repeat (2) tick();
    chk("glitch_idle_status", 32'(a_status), 32'(ST_IDLE));
    chk("glitch_idle_rst", 32'(a_proc_rst), 1);

    // Normal run: first high sample at edge k, RESET after edge k+10, RUN after k+14.
    start_process = 1'b1;
    tick();                 // edge k
    repeat (9) tick();      // edge k+9, last ARM cycle
    chk("arm_last_status", 32'(a_status), 32'(ST_IDLE));
    tick();                 // edge k+10
    chk("reset_status", 32'(a_status), 32'(ST_RUN));
    chk("reset_proc_rst", 32'(a_proc_rst), 1);
    chk("reset_proc_run", 32'(a_proc_run), 0);
    repeat (3) tick();      // edge k+13
    chk("reset_last_run", 32'(a_proc_run), 0);
    tick();                 // edge k+14
    chk("run_proc_run", 32'(a_proc_run), 1);
    chk("run_proc_rst", 32'(a_proc_rst), 0);
    chk("run_count0", 32'(a_count), 0);
    repeat (19) tick();
    chk("b_pre_to_status", 32'(b_status), 32'(ST_RUN));
    chk("b_pre_to_count", 32'(b_count), 19);
    tick();
    chk("b_fault_status", 32'(b_status), 32'(ST_FAULT));
    chk("b_fault_timeout", 32'(b_timeout), 1);
    chk("b_fault_count", 32'(b_count), 20);
    chk("b_fault_run", 32'(b_proc_run), 0);
    repeat (17) tick();
    chk("a_run_count37", 32'(a_count), 37);
    chk("a_run_timeout", 32'(a_timeout), 0);
    end_process = 1'b1;
    tick();
    end_process = 1'b0;
    chk("done_status", 32'(a_status), 32'(ST_DONE));
    chk("done_count", 32'(a_count), 37);
    chk("done_run", 32'(a_proc_run), 0);
    chk("done_proc_rst", 32'(a_proc_rst), 0);
    repeat (3) tick();
    chk("done_hold_status", 32'(a_status), 32'(ST_DONE));
    chk("done_hold_count", 32'(a_count), 37);
    start_process = 1'b0;
    tick();
    chk("release_status", 32'(a_status), 32'(ST_IDLE));
    chk("release_proc_rst", 32'(a_proc_rst), 1);
    chk("release_count", 32'(a_count), 37);
    chk("b_release_count", 32'(b_count), 20);
    chk("b_release_timeout", 32'(b_timeout), 1);

    // end_process on the same edge as the watchdog: DONE wins.
    start_process = 1'b1;
    repeat (11) tick();     // in RESET
    chk("tie_reset_timeout_clr", 32'(b_timeout), 0);
    chk("tie_reset_count_clr", 32'(b_count), 0);
    repeat (4) tick();
    chk("tie_run", 32'(b_proc_run), 1);
    repeat (19) tick();
    chk("tie_pre_count", 32'(b_count), 19);
    end_process = 1'b1;
    tick();
    end_process = 1'b0;
    chk("tie_b_status", 32'(b_status), 32'(ST_DONE));
    chk("tie_b_timeout", 32'(b_timeout), 0);
    chk("tie_b_count", 32'(b_count), 19);
    chk("tie_a_status", 32'(a_status), 32'(ST_DONE));
    start_process = 1'b0;
    tick();

    // Abort 3 cycles into RUN.
    start_process = 1'b1;
    repeat (15) tick();
    chk("abort_run", 32'(a_proc_run), 1);
    repeat (3) tick();
    start_process = 1'b0;
    tick();
    chk("abort_status", 32'(a_status), 32'(ST_IDLE));
    chk("abort_proc_rst", 32'(a_proc_rst), 1);
    chk("abort_proc_run", 32'(a_proc_run), 0);
    chk("abort_count", 32'(a_count), 3);

    // Restart clears the counter on RESET entry.
    start_process = 1'b1;
    repeat (11) tick();
    chk("restart_status", 32'(a_status), 32'(ST_RUN));
    chk("restart_proc_rst", 32'(a_proc_rst), 1);
    chk("restart_count", 32'(a_count), 0);
    repeat (9) tick();
    chk("restart_run_count", 32'(a_count), 5);

    // Synchronous reset mid-run overrides end_process.
    rst = 1'b1; end_process = 1'b1;
    tick();
    chk_reset_vals("midrun_rst");
    rst = 1'b0; end_process = 1'b0; start_process = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
